exc_ctrl: RTL and testbench

//  Exception arbiter and pipeline redirect controller; the producing end of the CP0 exception interface.

---
 rtl/exc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_exc_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl: exception arbiter and pipeline redirect controller.
//
// This block samples the MEM-stage exception flags and any pending interrupt,
// checking them against CP0 Status, Cause and EPC. When an exception is taken,
// it reports the winning exception to cp0_reg for one cycle, flushes the
// pipeline for FLUSH_CYCLES cycles, and then offers the new fetch PC over a
// valid/ack handshake.
//
// Optional feature (compile-time macro EXC_CP0_FWD_EN):
//   When EXC_CP0_FWD_EN is defined, Status, Cause[9:8] and EPC are forwarded
//   from an in-flight WB-stage CP0 write, so an exception in the same cycle
//   sees the value being written. When the macro is undefined, the WB ports
//   are ignored.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   valid_i, pc_i             MEM-stage instruction valid / address
//   in_delayslot_i            MEM-stage instruction is in a delay slot
//   exc_syscall_i ... _eret_i decoded exception flags
//   cp0_status/cause/epc_i    CP0 registers from cp0_reg
//   wb_cp0_we/waddr/data_i    WB-stage CP0 write (used only for forwarding)
//   excepttype_o              exception code, non-zero only in the report cycle
//   exc_pc_o, exc_delayslot_o faulting PC and delay-slot flag for the report
//   flush_o                   flush all pipeline registers
//   redirect_valid_o          new_pc_o is valid; held until redirect_ack_i
//   redirect_ack_i            fetch accepted new_pc_o
//   new_pc_o                  redirect target
// -----------------------------------------------------------------------------
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic        exc_syscall_i,
    input  logic        exc_invalid_i,
    input  logic        exc_trap_i,
    input  logic        exc_eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    input  logic        redirect_ack_i,
    output logic [31:0] new_pc_o
);

    localparam logic [31:0] CodeNone    = 32'h0000_0000;
    localparam logic [31:0] CodeInt     = 32'h0000_0001;
    localparam logic [31:0] CodeSyscall = 32'h0000_0008;
    localparam logic [31:0] CodeInvalid = 32'h0000_000a;
    localparam logic [31:0] CodeTrap    = 32'h0000_000d;
    localparam logic [31:0] CodeEret    = 32'h0000_000e;

    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRedirect
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic        exc_ds_q, exc_ds_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] st, ca, epc;
    logic        int_pending;
    logic [31:0] exc_code;

    // Effective CP0 view.
`ifdef EXC_CP0_FWD_EN
    always_comb begin
        st  = cp0_status_i;
        ca  = cp0_cause_i;
        epc = cp0_epc_i;
        if (wb_cp0_we_i) begin
            unique case (wb_cp0_waddr_i)
                5'd12:   st = wb_cp0_data_i;
                // Only the software-interrupt bits of Cause are writable.
                5'd13:   ca[9:8] = wb_cp0_data_i[9:8];
                5'd14:   epc = wb_cp0_data_i;
                default: ;
            endcase
        end
    end

    logic unused_cp0;
    assign unused_cp0 = ^{st[31:16], st[7:2], ca[31:16], ca[7:0]};
`else
    assign st  = cp0_status_i;
    assign ca  = cp0_cause_i;
    assign epc = cp0_epc_i;

    logic unused_cp0;
    assign unused_cp0 = ^{st[31:16], st[7:2], ca[31:16], ca[7:0],
                          wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i};
`endif

    // An interrupt is pending when it is unmasked, interrupts are enabled (IE), and the core
    // is not already at exception level (EXL).
    assign int_pending = ((ca[15:8] & st[15:8]) != 8'h00) && st[0] && !st[1];

    // Priority arbitration: only the highest-priority source is reported.
    always_comb begin
        exc_code = CodeNone;
        if (valid_i) begin
            if (int_pending)        exc_code = CodeInt;
            else if (exc_syscall_i) exc_code = CodeSyscall;
            else if (exc_invalid_i) exc_code = CodeInvalid;
            else if (exc_trap_i)    exc_code = CodeTrap;
            else if (exc_eret_i)    exc_code = CodeEret;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        excepttype_d = CodeNone;
        exc_pc_d     = 32'h0;
        exc_ds_d     = 1'b0;
        new_pc_d     = new_pc_q;
        unique case (state_q)
            StIdle: begin
                if (exc_code != CodeNone) begin
                    excepttype_d = exc_code;
                    exc_pc_d     = pc_i;
                    exc_ds_d     = in_delayslot_i;
                    new_pc_d     = (exc_code == CodeEret) ? epc : EXC_VECTOR;
                    cnt_d        = FlushInit;
                    state_d      = StFlush;
                end
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRedirect;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRedirect: begin
                if (redirect_ack_i) begin
                    state_d  = StIdle;
                    new_pc_d = 32'h0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            excepttype_q <= 32'h0;
            exc_pc_q     <= 32'h0;
            exc_ds_q     <= 1'b0;
            new_pc_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            excepttype_q <= excepttype_d;
            exc_pc_q     <= exc_pc_d;
            exc_ds_q     <= exc_ds_d;
            new_pc_q     <= new_pc_d;
        end
    end

    assign excepttype_o     = excepttype_q;
    assign exc_pc_o         = exc_pc_q;
    assign exc_delayslot_o  = exc_ds_q;
    assign flush_o          = (state_q == StFlush);
    assign redirect_valid_o = (state_q == StRedirect);
    assign new_pc_o         = new_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_ctrl: self-checking bench for exc_ctrl. Instance u_dut1 uses the
// default FLUSH_CYCLES=1 and u_dut3 uses FLUSH_CYCLES=3. Both share all
// stimulus except the redirect acknowledge.
// -----------------------------------------------------------------------------
module tb_exc_ctrl;

    typedef struct packed {
        logic [31:0] et;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] npc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, ds, sys, inv, trap, eret;
    logic [31:0] pc, st, ca, epc;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_data;
    logic        ack1, ack3;

    logic [31:0] et1, xpc1, npc1, et3, xpc3, npc3;
    logic        xds1, fl1, rv1, xds3, fl3, rv3;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    exc_ctrl u_dut1 (
        .clk(clk), .rst(rst), .valid_i(valid), .pc_i(pc), .in_delayslot_i(ds),
        .exc_syscall_i(sys), .exc_invalid_i(inv), .exc_trap_i(trap), .exc_eret_i(eret),
        .cp0_status_i(st), .cp0_cause_i(ca), .cp0_epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .excepttype_o(et1), .exc_pc_o(xpc1), .exc_delayslot_o(xds1), .flush_o(fl1),
        .redirect_valid_o(rv1), .redirect_ack_i(ack1), .new_pc_o(npc1)
    );

    exc_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .valid_i(valid), .pc_i(pc), .in_delayslot_i(ds),
        .exc_syscall_i(sys), .exc_invalid_i(inv), .exc_trap_i(trap), .exc_eret_i(eret),
        .cp0_status_i(st), .cp0_cause_i(ca), .cp0_epc_i(epc),
        .wb_cp0_we_i(wb_we), .wb_cp0_waddr_i(wb_waddr), .wb_cp0_data_i(wb_data),
        .excepttype_o(et3), .exc_pc_o(xpc3), .exc_delayslot_o(xds3), .flush_o(fl3),
        .redirect_valid_o(rv3), .redirect_ack_i(ack3), .new_pc_o(npc3)
    );

    task automatic clear_flags();
        valid = 1'b0; sys = 1'b0; inv = 1'b0; trap = 1'b0; eret = 1'b0; ds = 1'b0;
        wb_we = 1'b0; wb_waddr = 5'd0; wb_data = 32'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_flags();
        pc = 32'h0; st = 32'h0; ca = 32'h0; epc = 32'h0;
        ack1 = 1'b0; ack3 = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Caller sets the inputs at a negedge; this records the expectation, lets the
    // next rising edge sample the inputs, and returns in the report cycle.
    task automatic fire(input exp_t e);
        sb_q.push_back(e);
        @(negedge clk);
        clear_flags();
    endtask

    // Counts flush cycles until redirect_valid rises; the bound is 20 cycles.
    task automatic wait_redir(input bit sel3, output int nflush, output bit timed_out);
        nflush = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sel3 ? rv3 : rv1) begin
                timed_out = 1'b0;
                break;
            end
            if (sel3 ? fl3 : fl1) nflush++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_flags();
        pc = 32'h0; st = 32'h0; ca = 32'h0; epc = 32'h0; ack1 = 1'b0; ack3 = 1'b1;
        #12;
        n_cmp++;
        if ({et1, xpc1, xds1, fl1, rv1, npc1} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got et=%h pc=%h ds=%b fl=%b rv=%b npc=%h exp all 0",
                     et1, xpc1, xds1, fl1, rv1, npc1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_syscall();
        exp_t e; int nf; bit to;
        apply_reset();
        st = 32'h1000_0000; pc = 32'h100; sys = 1'b1; valid = 1'b1;
        fire('{et: 32'h8, pc: 32'h100, ds: 1'b0, npc: 32'h20});
        e = sb_q.pop_front();
        n_cmp++;
        if (et1 !== e.et || xpc1 !== e.pc || xds1 !== e.ds) begin
            n_bad++;
            $display("FAIL syscall_report got %h/%h/%b exp %h/%h/%b",
                     et1, xpc1, xds1, e.et, e.pc, e.ds);
        end
        n_cmp++;
        if (fl1 !== 1'b1 || rv1 !== 1'b0) begin
            n_bad++; $display("FAIL syscall_flush got fl=%b rv=%b exp fl=1 rv=0", fl1, rv1);
        end
        wait_redir(1'b0, nf, to);
        n_cmp++;
        if (to || nf != 1) begin
            n_bad++; $display("FAIL syscall_flush_len got %0d timeout=%b exp 1", nf, to);
        end
        n_cmp++;
        if (npc1 !== e.npc || et1 !== 32'h0 || fl1 !== 1'b0) begin
            n_bad++;
            $display("FAIL syscall_redirect got npc=%h et=%h fl=%b exp npc=%h et=0 fl=0",
                     npc1, et1, fl1, e.npc);
        end
        @(negedge clk);
        n_cmp++;
        if (rv1 !== 1'b1 || npc1 !== e.npc) begin
            n_bad++; $display("FAIL syscall_hold got rv=%b npc=%h exp 1/%h", rv1, npc1, e.npc);
        end
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
        n_cmp++;
        if (rv1 !== 1'b0) begin
            n_bad++; $display("FAIL syscall_ack got rv=%b exp 0", rv1);
        end
        // Ack while idle must not start anything.
        ack1 = 1'b1;
        repeat (2) @(negedge clk);
        ack1 = 1'b0;
        n_cmp++;
        if (rv1 !== 1'b0 || fl1 !== 1'b0 || et1 !== 32'h0) begin
            n_bad++;
            $display("FAIL idle_ack got rv=%b fl=%b et=%h exp 0/0/0", rv1, fl1, et1);
        end
    endtask

    task automatic test_eret();
        exp_t e; int nf; bit to;
        apply_reset();
        epc = 32'h0000_0400; pc = 32'h200; ds = 1'b1; eret = 1'b1; valid = 1'b1;
        fire('{et: 32'he, pc: 32'h200, ds: 1'b1, npc: 32'h400});
        e = sb_q.pop_front();
        n_cmp++;
        if (et1 !== e.et || xpc1 !== e.pc || xds1 !== e.ds) begin
            n_bad++;
            $display("FAIL eret_report got %h/%h/%b exp %h/%h/%b",
                     et1, xpc1, xds1, e.et, e.pc, e.ds);
        end
        wait_redir(1'b0, nf, to);
        n_cmp++;
        if (to || npc1 !== e.npc) begin
            n_bad++; $display("FAIL eret_newpc got %h timeout=%b exp %h", npc1, to, e.npc);
        end
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
    endtask

    task automatic test_priority();
        // flags = {sys, inv, trap, eret}
        logic [3:0]  flg [7];
        logic [31:0] sts [7];
        logic [31:0] cas [7];
        logic [31:0] exc [7];
        exp_t e; int nf; bit to;
        flg[0] = 4'b0010; sts[0] = 32'h401; cas[0] = 32'h400; exc[0] = 32'h1;
        flg[1] = 4'b0010; sts[1] = 32'h403; cas[1] = 32'h400; exc[1] = 32'hd;
        flg[2] = 4'b1111; sts[2] = 32'h0;   cas[2] = 32'h0;   exc[2] = 32'h8;
        flg[3] = 4'b0111; sts[3] = 32'h0;   cas[3] = 32'h0;   exc[3] = 32'ha;
        flg[4] = 4'b0011; sts[4] = 32'h0;   cas[4] = 32'h0;   exc[4] = 32'hd;
        flg[5] = 4'b0001; sts[5] = 32'h401; cas[5] = 32'h800; exc[5] = 32'he;
        flg[6] = 4'b0000; sts[6] = 32'h8001; cas[6] = 32'h8000; exc[6] = 32'h1;
        for (int i = 0; i < 7; i++) begin
            apply_reset();
            epc = 32'h0000_0300;
            st = sts[i]; ca = cas[i]; pc = 32'h1000 + 32'(i * 4); valid = 1'b1;
            {sys, inv, trap, eret} = flg[i];
            fire('{et: exc[i], pc: 32'h1000 + 32'(i * 4), ds: 1'b0,
                   npc: (exc[i] == 32'he) ? 32'h300 : 32'h20});
            e = sb_q.pop_front();
            n_cmp++;
            if (et1 !== e.et || xpc1 !== e.pc) begin
                n_bad++;
                $display("FAIL prio_%0d got et=%h pc=%h exp et=%h pc=%h", i, et1, xpc1, e.et, e.pc);
            end
            wait_redir(1'b0, nf, to);
            n_cmp++;
            if (to || npc1 !== e.npc) begin
                n_bad++; $display("FAIL prio_npc_%0d got %h timeout=%b exp %h", i, npc1, to, e.npc);
            end
            ack1 = 1'b1;
            @(negedge clk);
            ack1 = 1'b0;
        end
        // valid_i low: nothing is taken even with an interrupt pending.
        apply_reset();
        st = 32'h401; ca = 32'h400; sys = 1'b1; valid = 1'b0;
        repeat (3) @(negedge clk);
        clear_flags();
        n_cmp++;
        if (et1 !== 32'h0 || fl1 !== 1'b0 || rv1 !== 1'b0) begin
            n_bad++; $display("FAIL invalid_slot got et=%h fl=%b rv=%b exp 0/0/0", et1, fl1, rv1);
        end
    endtask

    task automatic test_ignore_busy();
        exp_t e; int nf; bit to;
        apply_reset();
        pc = 32'h500; sys = 1'b1; valid = 1'b1;
        fire('{et: 32'h8, pc: 32'h500, ds: 1'b0, npc: 32'h20});
        e = sb_q.pop_front();
        // New exception raised during FLUSH must be dropped.
        inv = 1'b1; valid = 1'b1; pc = 32'h504;
        @(negedge clk);
        clear_flags();
        n_cmp++;
        if (et1 !== 32'h0 || rv1 !== 1'b1) begin
            n_bad++; $display("FAIL busy_flush got et=%h rv=%b exp et=0 rv=1", et1, rv1);
        end
        eret = 1'b1; valid = 1'b1; epc = 32'h900;
        @(negedge clk);
        clear_flags();
        n_cmp++;
        if (et1 !== 32'h0 || rv1 !== 1'b1 || npc1 !== e.npc) begin
            n_bad++;
            $display("FAIL busy_redirect got et=%h rv=%b npc=%h exp 0/1/%h", et1, rv1, npc1, e.npc);
        end
        wait_redir(1'b0, nf, to);
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
    endtask

    task automatic test_flush3();
        exp_t e; int nf; bit to; int nvalid;
        apply_reset();
        ack3 = 1'b0;
        pc = 32'h600; sys = 1'b1; valid = 1'b1;
        fire('{et: 32'h8, pc: 32'h600, ds: 1'b0, npc: 32'h20});
        e = sb_q.pop_front();
        n_cmp++;
        if (et3 !== e.et || xpc3 !== e.pc) begin
            n_bad++; $display("FAIL f3_report got %h/%h exp %h/%h", et3, xpc3, e.et, e.pc);
        end
        wait_redir(1'b1, nf, to);
        n_cmp++;
        if (to || nf != 3) begin
            n_bad++; $display("FAIL f3_flush_len got %0d timeout=%b exp 3", nf, to);
        end
        nvalid = 0;
        for (int i = 0; i < 5; i++) begin
            if (rv3 === 1'b1 && npc3 === e.npc) nvalid++;
            if (i == 4) ack3 = 1'b1;
            @(negedge clk);
        end
        ack3 = 1'b0;
        n_cmp++;
        if (nvalid != 5 || rv3 !== 1'b0) begin
            n_bad++;
            $display("FAIL f3_hold got %0d stable cycles rv_after=%b exp 5 and 0", nvalid, rv3);
        end
    endtask

    task automatic test_fwd();
        exp_t e; int nf; bit to;
        logic [31:0] want;
`ifdef EXC_CP0_FWD_EN
        want = 32'h800;
`else
        want = 32'h400;
`endif
        apply_reset();
        epc = 32'h400; pc = 32'h700; eret = 1'b1; valid = 1'b1;
        wb_we = 1'b1; wb_waddr = 5'd14; wb_data = 32'h800;
        fire('{et: 32'he, pc: 32'h700, ds: 1'b0, npc: want});
        e = sb_q.pop_front();
        wait_redir(1'b0, nf, to);
        n_cmp++;
        if (to || npc1 !== e.npc) begin
            n_bad++; $display("FAIL fwd_epc got %h timeout=%b exp %h", npc1, to, e.npc);
        end
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e; int nf; bit to;
        apply_reset();
        pc = 32'h800; sys = 1'b1; valid = 1'b1;
        fire('{et: 32'h8, pc: 32'h800, ds: 1'b0, npc: 32'h20});
        e = sb_q.pop_front();
        wait_redir(1'b0, nf, to);
        n_cmp++;
        if (to || npc1 !== e.npc) begin
            n_bad++; $display("FAIL mid_pre got npc=%h timeout=%b exp %h", npc1, to, e.npc);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({et1, xpc1, xds1, fl1, rv1, npc1} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset got et=%h fl=%b rv=%b npc=%h exp all 0", et1, fl1, rv1, npc1);
        end
        @(negedge clk);
        rst = 1'b0;
        pc = 32'h900; sys = 1'b1; valid = 1'b1;
        fire('{et: 32'h8, pc: 32'h900, ds: 1'b0, npc: 32'h20});
        e = sb_q.pop_front();
        n_cmp++;
        if (et1 !== e.et || xpc1 !== e.pc || fl1 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_after got et=%h pc=%h fl=%b exp %h/%h/1", et1, xpc1, fl1, e.et, e.pc);
        end
        wait_redir(1'b0, nf, to);
        n_cmp++;
        if (to || npc1 !== e.npc) begin
            n_bad++; $display("FAIL mid_after_npc got %h timeout=%b exp %h", npc1, to, e.npc);
        end
        ack1 = 1'b1;
        @(negedge clk);
        ack1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_eret();
        test_priority();
        test_ignore_busy();
        test_flush3();
        test_fwd();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion exp finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
